// File: rtl/vec_strip_ctrl.sv
// Vector length configuration and element-issue sequencer.
// Holds the vl/vtype/avl_rem/vill CSRs and walks element indices for one
// operation at a time, honouring downstream stalls.
module vec_strip_ctrl #(
    parameter int VLEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_sew,
    input  logic [2:0] cfg_lmul,
    input  logic [6:0] cfg_avl,
    input  logic       cfg_use_rem,
    input  logic       op_valid,
    output logic       op_ready,
    output logic       elem_valid,
    output logic [6:0] elem_idx,
    output logic       elem_last,
    input  logic       elem_stall,
    output logic       op_done,
    output logic [6:0] vl,
    output logic [6:0] vtype,
    output logic [6:0] avl_rem,
    output logic       vill
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] VLEN_W = 7'(VLEN);

    state_t     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [6:0] vl_q, vl_d;
    logic [6:0] vtype_q, vtype_d;
    logic [6:0] rem_q, rem_d;
    logic       vill_q, vill_d;

    logic       cfg_legal;
    logic [6:0] avl_sel;
    logic [2:0] sew_shift;
    logic [6:0] vlmax;
    logic [6:0] vl_calc;
    logic       at_last;

    // Config datapath: VLMAX from SEW/LMUL, then vl = min(VLMAX, AVL)
    always_comb begin
        cfg_legal = ~cfg_sew[2] & ~cfg_lmul[2];
        avl_sel   = cfg_use_rem ? rem_q : cfg_avl;
        sew_shift = {1'b0, cfg_sew[1:0]} + 3'd3;
        vlmax     = (VLEN_W >> sew_shift) << cfg_lmul[1:0];
        vl_calc   = (avl_sel < vlmax) ? avl_sel : vlmax;
    end

    assign at_last = (idx_q == (vl_q - 7'd1));

    // Next-state, CSR update and handshake outputs; config beats op in IDLE
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vl_d       = vl_q;
        vtype_d    = vtype_q;
        rem_d      = rem_q;
        vill_d     = vill_q;
        cfg_ready  = 1'b0;
        op_ready   = 1'b0;
        elem_valid = 1'b0;
        op_done    = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                op_ready  = ~cfg_valid;
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        vl_d    = vl_calc;
                        rem_d   = avl_sel - vl_calc;
                        vtype_d = {1'b1, cfg_sew, cfg_lmul};
                        vill_d  = 1'b0;
                    end else begin
                        vl_d    = 7'd0;
                        rem_d   = 7'd0;
                        vtype_d = 7'd0;
                        vill_d  = 1'b1;
                    end
                end else if (op_valid) begin
                    idx_d = 7'd0;
                    if ((vl_q == 7'd0) || vill_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                elem_valid = 1'b1;
                if (!elem_stall) begin
                    if (at_last) begin
                        idx_d   = 7'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            DONE: begin
                op_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, element index and CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            vl_q    <= 7'd0;
            vtype_q <= 7'd0;
            rem_q   <= 7'd0;
            vill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
            vtype_q <= vtype_d;
            rem_q   <= rem_d;
            vill_q  <= vill_d;
        end
    end

    assign elem_idx  = idx_q;
    assign elem_last = elem_valid & at_last;
    assign vl        = vl_q;
    assign vtype     = vtype_q;
    assign avl_rem   = rem_q;
    assign vill      = vill_q;

endmodule

// File: tb/tb_vec_strip_ctrl.sv
// Directed scoreboard bench for vec_strip_ctrl: expected CSR values and
// element indices are queued when stimulus is driven and popped when the
// design produces them.
module tb_vec_strip_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_sew;
    logic [2:0] cfg_lmul;
    logic [6:0] cfg_avl;
    logic       cfg_use_rem;
    logic       op_valid;
    logic       op_ready;
    logic       elem_valid;
    logic [6:0] elem_idx;
    logic       elem_last;
    logic       elem_stall;
    logic       op_done;
    logic [6:0] vl;
    logic [6:0] vtype;
    logic [6:0] avl_rem;
    logic       vill;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = 0;
    int done_count = 0;

    typedef struct packed {
        logic [6:0] idx;
        logic       last;
    } elem_t;

    typedef struct packed {
        logic [6:0] vl;
        logic [6:0] vtype;
        logic [6:0] rem;
        logic       vill;
    } csr_t;

    elem_t exp_elem[$];
    csr_t  exp_csr[$];

    // reference model of the CSRs
    logic [6:0] m_vl;
    logic [6:0] m_rem;
    logic       m_vill;

    vec_strip_ctrl #(.VLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sew    (cfg_sew),
        .cfg_lmul   (cfg_lmul),
        .cfg_avl    (cfg_avl),
        .cfg_use_rem(cfg_use_rem),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .elem_valid (elem_valid),
        .elem_idx   (elem_idx),
        .elem_last  (elem_last),
        .elem_stall (elem_stall),
        .op_done    (op_done),
        .vl         (vl),
        .vtype      (vtype),
        .avl_rem    (avl_rem),
        .vill       (vill)
    );

    // 10-unit clock and a free-running cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // hard stop in case a bounded wait is ever bypassed
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"},  cfg_ready,  1);
        check({tag, "_op_ready"},   op_ready,   1);
        check({tag, "_elem_valid"}, elem_valid, 0);
        check({tag, "_elem_idx"},   elem_idx,   0);
        check({tag, "_elem_last"},  elem_last,  0);
        check({tag, "_op_done"},    op_done,    0);
        check({tag, "_vl"},         vl,         0);
        check({tag, "_vtype"},      vtype,      0);
        check({tag, "_avl_rem"},    avl_rem,    0);
        check({tag, "_vill"},       vill,       0);
    endtask

    // Called at posedge+1 with inputs already driven: sample, score, advance
    task automatic sample_cycle();
        elem_t e;
        #1;
        if (elem_valid && !elem_stall) begin
            checks++;
            assert (exp_elem.size() != 0) else begin
                errors++;
                $error("[TB] FAIL elem_unexpected observed idx=%0d required=no element", elem_idx);
            end
            if (exp_elem.size() != 0) begin
                e = exp_elem.pop_front();
                check("elem_idx", elem_idx, e.idx);
                check("elem_last", elem_last, e.last);
            end
        end
        if (op_done) begin
            done_count++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    // One config request; the expected CSRs come from the model
    task automatic apply_cfg(input int sew, input int lmul, input int avl, input bit use_rem, input bit with_op);
        csr_t c;
        int   avl_m;
        int   vlmax_m;
        int   vl_m;
        csr_t got;
        if (sew >= 4 || lmul >= 4) begin
            c.vl = 0; c.rem = 0; c.vtype = 0; c.vill = 1'b1;
        end else begin
            avl_m   = use_rem ? int'(m_rem) : avl;
            vlmax_m = (64 / (8 * (1 << sew))) * (1 << lmul);
            vl_m    = (avl_m < vlmax_m) ? avl_m : vlmax_m;
            c.vl    = 7'(vl_m);
            c.rem   = 7'(avl_m - vl_m);
            c.vtype = 7'((1 << 6) | (sew << 3) | lmul);
            c.vill  = 1'b0;
        end
        exp_csr.push_back(c);
        m_vl   = c.vl;
        m_rem  = c.rem;
        m_vill = c.vill;

        cfg_valid   = 1'b1;
        cfg_sew     = 3'(sew);
        cfg_lmul    = 3'(lmul);
        cfg_avl     = 7'(avl);
        cfg_use_rem = use_rem;
        op_valid    = with_op;
        #1;
        check("cfg_ready", cfg_ready, 1);
        if (with_op) check("op_ready_cfg_wins", op_ready, 0);
        @(posedge clk);
        #1;
        cfg_valid   = 1'b0;
        cfg_use_rem = 1'b0;
        got = exp_csr.pop_front();
        check("vl", vl, got.vl);
        check("vtype", vtype, got.vtype);
        check("avl_rem", avl_rem, got.rem);
        check("vill", vill, got.vill);
    endtask

    // One operation with an optional stall window; checks done latency
    task automatic run_op(input int stall_at, input int stall_len, input int exp_lat);
        int    k;
        int    stalls;
        int    acc_cyc;
        elem_t e;
        op_valid = 1'b1;
        #1;
        k = 0;
        while (!op_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        assert (op_ready) else begin
            errors++;
            $error("[TB] FAIL op_accept observed op_ready=%0d required=1", op_ready);
        end
        if (!op_ready) begin
            op_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (!m_vill && m_vl != 0) begin
            for (int i = 0; i < int'(m_vl); i++) begin
                e.idx  = 7'(i);
                e.last = (i == int'(m_vl) - 1);
                exp_elem.push_back(e);
            end
        end
        done_count = 0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        stalls = 0;
        k = 0;
        while (done_count == 0 && k < 300) begin
            elem_stall = elem_valid && (int'(elem_idx) == stall_at) && (stalls < stall_len);
            if (elem_stall) stalls++;
            sample_cycle();
            k++;
        end
        elem_stall = 1'b0;
        check("op_done_seen", done_count, 1);
        check("op_latency", done_cyc - acc_cyc, exp_lat);
        check("scoreboard_empty", exp_elem.size(), 0);
        check("op_done_single", op_done, 0);
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_sew     = 3'd0;
        cfg_lmul    = 3'd0;
        cfg_avl     = 7'd0;
        cfg_use_rem = 1'b0;
        op_valid    = 1'b0;
        elem_stall  = 1'b0;
        m_vl        = 7'd0;
        m_rem       = 7'd0;
        m_vill      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // strip-mining chain, ending with an empty strip
        $display("[TB] strip-mining sequence");
        apply_cfg(2, 0, 5, 1'b0, 1'b0);
        apply_cfg(2, 0, 0, 1'b1, 1'b0);
        apply_cfg(2, 0, 0, 1'b1, 1'b0);
        apply_cfg(2, 0, 0, 1'b1, 1'b0);
        run_op(-1, 0, 1);
        apply_cfg(3, 0, 0, 1'b0, 1'b0);

        // full-length vector, vl = 64
        $display("[TB] vl=64 operation");
        apply_cfg(0, 3, 100, 1'b0, 1'b0);
        run_op(-1, 0, 65);

        // illegal SEW
        $display("[TB] illegal configuration");
        apply_cfg(4, 0, 10, 1'b0, 1'b0);
        run_op(-1, 0, 1);

        // stall at idx 1 for two cycles
        $display("[TB] stalled operation");
        apply_cfg(0, 0, 3, 1'b0, 1'b0);
        run_op(1, 2, 6);

        // config and op in the same cycle
        $display("[TB] simultaneous config and op");
        apply_cfg(1, 1, 20, 1'b0, 1'b1);
        run_op(-1, 0, 9);

        // async reset in the middle of an operation
        $display("[TB] reset during RUN");
        apply_cfg(0, 0, 8, 1'b0, 1'b0);
        run_op(-1, 0, 9);
        op_valid = 1'b1;
        #1;
        check("abort_op_ready", op_ready, 1);
        for (int i = 0; i < 8; i++) begin
            elem_t e;
            e.idx  = 7'(i);
            e.last = (i == 7);
            exp_elem.push_back(e);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        done_count = 0;
        k = 0;
        while (!(elem_valid && elem_idx == 7'd4) && k < 20) begin
            sample_cycle();
            k++;
        end
        check("abort_reached_idx4", elem_idx, 4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_elem.delete();
        m_vl   = 7'd0;
        m_rem  = 7'd0;
        m_vill = 1'b0;
        repeat (2) sample_cycle();
        rst = 1'b0;
        repeat (3) sample_cycle();
        check("abort_no_op_done", done_count, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        check("abort_elem_valid", elem_valid, 0);

        // the design is usable again after the abort
        apply_cfg(0, 1, 10, 1'b0, 1'b0);
        run_op(-1, 0, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
